// File: rtl/fetch_req_tracker_pkg.sv
// rtl/fetch_req_tracker_pkg.sv - shared front-end constants and fetch metadata type
package fetch_req_tracker_pkg;

    localparam int SINGLE_WORD = 32;
    localparam int EXCCODE     = 5;
    localparam int INST_NUM    = 4;
    localparam int FRT_DEPTH   = 4;

    localparam logic [SINGLE_WORD-1:0] ZEROWORD = '0;
    localparam logic                   FALSE    = 1'b0;

    // Address error on instruction fetch
    localparam logic [EXCCODE-1:0] EXC_ADEL = 5'h04;

    typedef struct packed {
        logic [SINGLE_WORD-1:0] vaddr;
        logic [INST_NUM-1:0]    inst_enable;
        logic                   need_delay_slot;
        logic                   has_exception;
        logic [EXCCODE-1:0]     exc_code;
    } frt_meta_t;

endpackage

// File: rtl/fetch_req_tracker_meta_fifo.sv
// rtl/fetch_req_tracker_meta_fifo.sv - in-order metadata FIFO with per-entry kill bits
// Ports: push_i/push_data_i write at the tail, pop_i retires the head,
// kill_all_i marks every live entry (and a same-cycle push) as killed.
// head_o/head_kill_o show the head entry, count_o the occupancy,
// live_vec_o the entries that are valid and not killed.
module frt_meta_fifo
    import fetch_req_tracker_pkg::*;
#(
    parameter int DEPTH = FRT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  frt_meta_t                    push_data_i,
    input  logic                         pop_i,
    input  logic                         kill_all_i,
    output frt_meta_t                    head_o,
    output logic                         head_kill_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [DEPTH-1:0]             live_vec_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    frt_meta_t         mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  kill_q,  kill_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    always_comb begin
        valid_d  = valid_q;
        kill_d   = kill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (kill_all_i) begin
            kill_d = kill_q | valid_q;
        end
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        // The caller never pushes when full, so the tail slot is free and
        // never aliases the head being popped.
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
            kill_d[wr_ptr_q]  = kill_all_i;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end

        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            kill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            kill_q   <= kill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign head_kill_o = kill_q[rd_ptr_q];
    assign count_o     = count_q;
    assign live_vec_o  = valid_q & ~kill_q;

endmodule

// File: rtl/fetch_req_tracker.sv
// rtl/fetch_req_tracker.sv - tracks I-Cache fetches from address accept to data return
// Ports: inst_req_i/inst_index_ok_i accept a PCR_* request, inst_data_ok_i/
// inst_rdata_i return it in order; CP0/SBA/BSC redirects kill in-flight
// requests; IQ_freeGroups_i throttles FRT_stopFetch_o; FRT_* is the output
// group, FRT_outstanding_o the live request count, FRT_protoErr_o sticky.
module fetch_req_tracker
    import fetch_req_tracker_pkg::*;
#(
    parameter int DEPTH = FRT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_req_i,
    input  logic                         inst_index_ok_i,
    input  logic [31:0]                  PCR_VAddr_i,
    input  logic [3:0]                   PCR_instEnable_i,
    input  logic                         PCR_needDelaySlot_i,
    input  logic                         PCR_hasException_i,
    input  logic [4:0]                   PCR_ExcCode_i,
    input  logic                         inst_data_ok_i,
    input  logic [127:0]                 inst_rdata_i,
    input  logic                         CP0_excOccur_w_i,
    input  logic                         SBA_flush_w_i,
    input  logic                         BSC_isDiffRes_w_i,
    input  logic [2:0]                   IQ_freeGroups_i,
    output logic                         FRT_stopFetch_o,
    output logic                         FRT_valid_o,
    output logic [31:0]                  FRT_VAddr_o,
    output logic [3:0]                   FRT_instEnable_o,
    output logic [127:0]                 FRT_inst_o,
    output logic                         FRT_needDelaySlot_o,
    output logic                         FRT_hasException_o,
    output logic [4:0]                   FRT_ExcCode_o,
    output logic [$clog2(DEPTH+1)-1:0]   FRT_outstanding_o,
    output logic                         FRT_protoErr_o
);

    localparam int CW = $clog2(DEPTH+1);

    logic             redirect;
    logic             accept;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             deliver;
    frt_meta_t        push_meta;
    frt_meta_t        head_meta;
    logic             head_kill;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] live_vec;
    logic [7:0]       live_cnt;

    logic             valid_q,   valid_d;
    frt_meta_t        meta_q,    meta_d;
    logic [127:0]     inst_q,    inst_d;
    logic             proto_err_q, proto_err_d;

    assign redirect = CP0_excOccur_w_i | SBA_flush_w_i | BSC_isDiffRes_w_i;
    assign accept   = inst_req_i & inst_index_ok_i;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = accept & ~full;
    assign pop      = inst_data_ok_i & ~empty;
    // A return coinciding with a redirect belongs to the old path.
    assign deliver  = pop & ~head_kill & ~redirect;

    assign push_meta = '{
        vaddr:           PCR_VAddr_i,
        inst_enable:     PCR_instEnable_i,
        need_delay_slot: PCR_needDelaySlot_i,
        has_exception:   PCR_hasException_i,
        exc_code:        PCR_ExcCode_i
    };

    frt_meta_fifo #(
        .DEPTH (DEPTH)
    ) u_meta_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_meta),
        .pop_i       (pop),
        .kill_all_i  (redirect),
        .head_o      (head_meta),
        .head_kill_o (head_kill),
        .count_o     (count),
        .live_vec_o  (live_vec)
    );

    always_comb begin
        valid_d     = deliver;
        meta_d      = meta_q;
        inst_d      = inst_q;
        proto_err_d = proto_err_q;
        if (deliver) begin
            meta_d = head_meta;
            // Faulting fetches never carry real instruction bits downstream.
            inst_d = head_meta.has_exception ? '0 : inst_rdata_i;
        end
        if ((inst_data_ok_i & empty) | (accept & full)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            meta_q      <= '0;
            inst_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            meta_q      <= meta_d;
            inst_q      <= inst_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Groups that can still land in the IQ: unkilled in-flight requests
    // plus the one sitting in the output register.
    always_comb begin
        live_cnt = 8'(valid_q);
        for (int i = 0; i < DEPTH; i++) begin
            live_cnt = live_cnt + 8'(live_vec[i]);
        end
    end

    assign FRT_stopFetch_o     = rst & (full | (live_cnt >= 8'(IQ_freeGroups_i)));
    assign FRT_outstanding_o   = rst ? count : '0;
    assign FRT_valid_o         = valid_q & ~redirect;
    assign FRT_VAddr_o         = meta_q.vaddr;
    assign FRT_instEnable_o    = meta_q.inst_enable;
    assign FRT_needDelaySlot_o = meta_q.need_delay_slot;
    assign FRT_hasException_o  = meta_q.has_exception;
    assign FRT_ExcCode_o       = meta_q.exc_code;
    assign FRT_inst_o          = inst_q;
    assign FRT_protoErr_o      = proto_err_q;

endmodule

// File: tb/tb_fetch_req_tracker.sv
// tb/tb_fetch_req_tracker.sv - directed self-checking bench for fetch_req_tracker
module tb_fetch_req_tracker;

    logic         clk;
    logic         rst;
    logic         inst_req_i;
    logic         inst_index_ok_i;
    logic [31:0]  PCR_VAddr_i;
    logic [3:0]   PCR_instEnable_i;
    logic         PCR_needDelaySlot_i;
    logic         PCR_hasException_i;
    logic [4:0]   PCR_ExcCode_i;
    logic         inst_data_ok_i;
    logic [127:0] inst_rdata_i;
    logic         CP0_excOccur_w_i;
    logic         SBA_flush_w_i;
    logic         BSC_isDiffRes_w_i;
    logic [2:0]   IQ_freeGroups_i;
    logic         FRT_stopFetch_o;
    logic         FRT_valid_o;
    logic [31:0]  FRT_VAddr_o;
    logic [3:0]   FRT_instEnable_o;
    logic [127:0] FRT_inst_o;
    logic         FRT_needDelaySlot_o;
    logic         FRT_hasException_o;
    logic [4:0]   FRT_ExcCode_o;
    logic [2:0]   FRT_outstanding_o;
    logic         FRT_protoErr_o;

    int tests;
    int fails;

    fetch_req_tracker #(.DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .inst_req_i          (inst_req_i),
        .inst_index_ok_i     (inst_index_ok_i),
        .PCR_VAddr_i         (PCR_VAddr_i),
        .PCR_instEnable_i    (PCR_instEnable_i),
        .PCR_needDelaySlot_i (PCR_needDelaySlot_i),
        .PCR_hasException_i  (PCR_hasException_i),
        .PCR_ExcCode_i       (PCR_ExcCode_i),
        .inst_data_ok_i      (inst_data_ok_i),
        .inst_rdata_i        (inst_rdata_i),
        .CP0_excOccur_w_i    (CP0_excOccur_w_i),
        .SBA_flush_w_i       (SBA_flush_w_i),
        .BSC_isDiffRes_w_i   (BSC_isDiffRes_w_i),
        .IQ_freeGroups_i     (IQ_freeGroups_i),
        .FRT_stopFetch_o     (FRT_stopFetch_o),
        .FRT_valid_o         (FRT_valid_o),
        .FRT_VAddr_o         (FRT_VAddr_o),
        .FRT_instEnable_o    (FRT_instEnable_o),
        .FRT_inst_o          (FRT_inst_o),
        .FRT_needDelaySlot_o (FRT_needDelaySlot_o),
        .FRT_hasException_o  (FRT_hasException_o),
        .FRT_ExcCode_o       (FRT_ExcCode_o),
        .FRT_outstanding_o   (FRT_outstanding_o),
        .FRT_protoErr_o      (FRT_protoErr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req_i          = 1'b0;
        inst_index_ok_i     = 1'b0;
        PCR_VAddr_i         = '0;
        PCR_instEnable_i    = '0;
        PCR_needDelaySlot_i = 1'b0;
        PCR_hasException_i  = 1'b0;
        PCR_ExcCode_i       = '0;
        inst_data_ok_i      = 1'b0;
        inst_rdata_i        = '0;
        CP0_excOccur_w_i    = 1'b0;
        SBA_flush_w_i       = 1'b0;
        BSC_isDiffRes_w_i   = 1'b0;
    endtask

    task automatic set_accept(input logic [31:0] va, input logic [3:0] en,
                              input logic exc, input logic [4:0] code);
        inst_req_i         = 1'b1;
        inst_index_ok_i    = 1'b1;
        PCR_VAddr_i        = va;
        PCR_instEnable_i   = en;
        PCR_hasException_i = exc;
        PCR_ExcCode_i      = code;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        IQ_freeGroups_i = 3'd7;
        rst = 1'b0;
        step();
        step();
        #1;
        tests++;
        if (FRT_outstanding_o !== 3'd0) begin
            fails++; $display("FAIL reset_outstanding got %0d want 0", FRT_outstanding_o);
        end
        tests++;
        if (FRT_stopFetch_o !== 1'b0) begin
            fails++; $display("FAIL reset_stop got %b want 0", FRT_stopFetch_o);
        end
        tests++;
        if (FRT_valid_o !== 1'b0 || FRT_protoErr_o !== 1'b0 || FRT_VAddr_o !== 32'h0 || FRT_inst_o !== 128'h0) begin
            fails++; $display("FAIL reset_regs valid=%b perr=%b va=%h want 0/0/0", FRT_valid_o, FRT_protoErr_o, FRT_VAddr_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        set_accept(32'hBFC0_0000, 4'b1111, 1'b0, 5'd0);
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_outstanding_o !== 3'd1 || FRT_valid_o !== 1'b0) begin
            fails++; $display("FAIL basic_after_accept outst=%0d valid=%b want 1/0", FRT_outstanding_o, FRT_valid_o);
        end
        step();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 128'h0123;
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_valid_o !== 1'b1 || FRT_VAddr_o !== 32'hBFC0_0000 || FRT_inst_o !== 128'h0123 ||
            FRT_instEnable_o !== 4'b1111 || FRT_outstanding_o !== 3'd0) begin
            fails++; $display("FAIL basic_return valid=%b va=%h inst=%h en=%b outst=%0d want 1/bfc00000/123/1111/0",
                              FRT_valid_o, FRT_VAddr_o, FRT_inst_o, FRT_instEnable_o, FRT_outstanding_o);
        end
        step();
        tests++;
        if (FRT_valid_o !== 1'b0) begin
            fails++; $display("FAIL basic_one_cycle valid=%b want 0", FRT_valid_o);
        end
    endtask

    task automatic test_fill();
        IQ_freeGroups_i = 3'd7;
        for (int i = 0; i < 4; i++) begin
            set_accept(32'(i * 16), 4'b1111, 1'b0, 5'd0);
            step();
            idle_inputs();
            #1;
            if (i == 2) begin
                tests++;
                if (FRT_stopFetch_o !== 1'b0) begin
                    fails++; $display("FAIL fill_stop_at3 got %b want 0", FRT_stopFetch_o);
                end
            end
        end
        tests++;
        if (FRT_outstanding_o !== 3'd4 || FRT_stopFetch_o !== 1'b1) begin
            fails++; $display("FAIL fill_full outst=%0d stop=%b want 4/1", FRT_outstanding_o, FRT_stopFetch_o);
        end
        for (int i = 0; i < 4; i++) begin
            inst_data_ok_i = 1'b1;
            inst_rdata_i   = 128'(i + 32'hA0);
            step();
            idle_inputs();
            #1;
            tests++;
            if (FRT_valid_o !== 1'b1 || FRT_VAddr_o !== 32'(i * 16) || FRT_inst_o !== 128'(i + 32'hA0)) begin
                fails++; $display("FAIL fill_order%0d valid=%b va=%h inst=%h want 1/%h/%h",
                                  i, FRT_valid_o, FRT_VAddr_o, FRT_inst_o, i * 16, i + 32'hA0);
            end
            if (i == 0) begin
                tests++;
                if (FRT_stopFetch_o !== 1'b0) begin
                    fails++; $display("FAIL fill_stop_release got %b want 0", FRT_stopFetch_o);
                end
            end
        end
        step();
        tests++;
        if (FRT_valid_o !== 1'b0 || FRT_outstanding_o !== 3'd0) begin
            fails++; $display("FAIL fill_drained valid=%b outst=%0d want 0/0", FRT_valid_o, FRT_outstanding_o);
        end
    endtask

    task automatic test_redirect_kill();
        for (int i = 0; i < 3; i++) begin
            set_accept(32'h1000 + 32'(i * 16), 4'b1111, 1'b0, 5'd0);
            step();
        end
        set_accept(32'h1030, 4'b1111, 1'b0, 5'd0);
        SBA_flush_w_i = 1'b1;
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_outstanding_o !== 3'd4) begin
            fails++; $display("FAIL kill_count got %0d want 4", FRT_outstanding_o);
        end
        for (int i = 0; i < 4; i++) begin
            inst_data_ok_i = 1'b1;
            inst_rdata_i   = 128'hDEAD;
            step();
            idle_inputs();
            #1;
            tests++;
            if (FRT_valid_o !== 1'b0 || FRT_outstanding_o !== 3'(3 - i)) begin
                fails++; $display("FAIL kill_drop%0d valid=%b outst=%0d want 0/%0d", i, FRT_valid_o, FRT_outstanding_o, 3 - i);
            end
        end
        tests++;
        if (FRT_protoErr_o !== 1'b0) begin
            fails++; $display("FAIL kill_no_perr got %b want 0", FRT_protoErr_o);
        end
    endtask

    task automatic test_redirect_output();
        set_accept(32'h2000, 4'b0011, 1'b0, 5'd0);
        step();
        idle_inputs();
        step();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 128'h55;
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_valid_o !== 1'b1) begin
            fails++; $display("FAIL redir_out_pre valid=%b want 1", FRT_valid_o);
        end
        CP0_excOccur_w_i = 1'b1;
        #1;
        tests++;
        if (FRT_valid_o !== 1'b0) begin
            fails++; $display("FAIL redir_out_suppress valid=%b want 0", FRT_valid_o);
        end
        step();
        idle_inputs();
        // Return in the same cycle as a redirect is dropped.
        set_accept(32'h3000, 4'b1111, 1'b0, 5'd0);
        step();
        idle_inputs();
        inst_data_ok_i    = 1'b1;
        inst_rdata_i      = 128'h77;
        BSC_isDiffRes_w_i = 1'b1;
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_valid_o !== 1'b0 || FRT_outstanding_o !== 3'd0) begin
            fails++; $display("FAIL redir_same_cycle valid=%b outst=%0d want 0/0", FRT_valid_o, FRT_outstanding_o);
        end
    endtask

    task automatic test_throttle();
        IQ_freeGroups_i = 3'd1;
        set_accept(32'h4000, 4'b1111, 1'b0, 5'd0);
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_stopFetch_o !== 1'b1) begin
            fails++; $display("FAIL throttle_free1 stop=%b want 1", FRT_stopFetch_o);
        end
        IQ_freeGroups_i = 3'd2;
        #1;
        tests++;
        if (FRT_stopFetch_o !== 1'b0) begin
            fails++; $display("FAIL throttle_free2 stop=%b want 0", FRT_stopFetch_o);
        end
        inst_data_ok_i = 1'b1;
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_valid_o !== 1'b1 || FRT_stopFetch_o !== 1'b0) begin
            fails++; $display("FAIL throttle_drain valid=%b stop=%b want 1/0", FRT_valid_o, FRT_stopFetch_o);
        end
        IQ_freeGroups_i = 3'd1;
        #1;
        tests++;
        if (FRT_stopFetch_o !== 1'b1) begin
            fails++; $display("FAIL throttle_validq stop=%b want 1", FRT_stopFetch_o);
        end
        IQ_freeGroups_i = 3'd7;
        step();
    endtask

    task automatic test_exception_proto();
        set_accept(32'h8000_0001, 4'b0001, 1'b1, 5'h04);
        step();
        idle_inputs();
        step();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 128'hFFFF_FFFF;
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_valid_o !== 1'b1 || FRT_inst_o !== 128'h0 || FRT_hasException_o !== 1'b1 ||
            FRT_ExcCode_o !== 5'h04 || FRT_VAddr_o !== 32'h8000_0001) begin
            fails++; $display("FAIL exc_return valid=%b inst=%h exc=%b code=%h va=%h want 1/0/1/04/80000001",
                              FRT_valid_o, FRT_inst_o, FRT_hasException_o, FRT_ExcCode_o, FRT_VAddr_o);
        end
        step();
        tests++;
        if (FRT_protoErr_o !== 1'b0) begin
            fails++; $display("FAIL perr_before got %b want 0", FRT_protoErr_o);
        end
        inst_data_ok_i = 1'b1;
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_protoErr_o !== 1'b1 || FRT_valid_o !== 1'b0 || FRT_outstanding_o !== 3'd0) begin
            fails++; $display("FAIL perr_empty perr=%b valid=%b outst=%0d want 1/0/0", FRT_protoErr_o, FRT_valid_o, FRT_outstanding_o);
        end
        step();
        step();
        tests++;
        if (FRT_protoErr_o !== 1'b1) begin
            fails++; $display("FAIL perr_sticky got %b want 1", FRT_protoErr_o);
        end
        do_reset();
        #1;
        tests++;
        if (FRT_protoErr_o !== 1'b0) begin
            fails++; $display("FAIL perr_cleared got %b want 0", FRT_protoErr_o);
        end
    endtask

    task automatic test_full_error();
        for (int i = 0; i < 4; i++) begin
            set_accept(32'h5000 + 32'(i * 16), 4'b1111, 1'b0, 5'd0);
            step();
        end
        set_accept(32'h5040, 4'b1111, 1'b0, 5'd0);
        step();
        idle_inputs();
        #1;
        tests++;
        if (FRT_outstanding_o !== 3'd4 || FRT_protoErr_o !== 1'b1) begin
            fails++; $display("FAIL full_accept outst=%0d perr=%b want 4/1", FRT_outstanding_o, FRT_protoErr_o);
        end
        // Oldest entry must still be at the head, the rejected push never landed.
        for (int i = 0; i < 4; i++) begin
            inst_data_ok_i = 1'b1;
            inst_rdata_i   = 128'(i);
            step();
            idle_inputs();
            #1;
            tests++;
            if (FRT_valid_o !== 1'b1 || FRT_VAddr_o !== 32'h5000 + 32'(i * 16)) begin
                fails++; $display("FAIL full_order%0d valid=%b va=%h want 1/%h", i, FRT_valid_o, FRT_VAddr_o, 32'h5000 + i * 16);
            end
        end
        step();
        tests++;
        if (FRT_outstanding_o !== 3'd0) begin
            fails++; $display("FAIL full_drain outst=%0d want 0", FRT_outstanding_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        IQ_freeGroups_i = 3'd7;
        idle_inputs();
        test_reset();
        test_basic();
        test_fill();
        test_redirect_kill();
        test_redirect_output();
        test_throttle();
        test_exception_proto();
        test_full_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_req_tracker.md
# fetch_req_tracker

Tracks I-Cache fetch requests between address acceptance (`inst_index_ok`) and data return (`inst_data_ok`). Sits between PCRegister, the I-Cache and the instruction queue (IQ). It keeps per-request metadata in a small in-order FIFO and kills in-flight requests on any front-end redirect. It also throttles fetch through `FRT_stopFetch_o`, which drives the IQ-side stop input of PCRegister, so that returning groups never overflow the IQ.

## Interface
- DEPTH, 4, maximum outstanding requests; power of two, ≥2
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- inst_req_i  in  1  PCRegister request
- inst_index_ok_i  in  1  I-Cache address accept; accept = inst_req_i & inst_index_ok_i
- PCR_VAddr_i  in  32  aligned fetch VAddr of the request being accepted
- PCR_instEnable_i  in  4  slot enables of that request
- PCR_needDelaySlot_i  in  1  group carries a delay slot
- PCR_hasException_i  in  1  fetch-address exception
- PCR_ExcCode_i  in  5  exception code
- inst_data_ok_i  in  1  I-Cache data return, in order
- inst_rdata_i  in  128  four instructions
- CP0_excOccur_w_i, SBA_flush_w_i, BSC_isDiffRes_w_i  in  1 each  redirect sources; redirect = OR of the three
- IQ_freeGroups_i  in  3  free 4-instruction groups in the IQ
- FRT_stopFetch_o  out  1  stop fetching
- FRT_valid_o  out  1  output group valid (single-cycle)
- FRT_VAddr_o  out  32, FRT_instEnable_o  out  4, FRT_inst_o  out  128, FRT_needDelaySlot_o  out  1, FRT_hasException_o  out  1, FRT_ExcCode_o  out  5  output group
- FRT_outstanding_o  out  $clog2(DEPTH+1)  live request count
- FRT_protoErr_o  out  1  sticky protocol-error flag

## Operation
- **Accept.** On accept, push {VAddr, instEnable, needDelaySlot, hasException, ExcCode, kill=0} at the write pointer. The count increments.
- **Exception requests.** Requests with hasException=1 are still tracked. On their return, inst data is forced to 0 and the exception fields pass through.
- **Return.** On `inst_data_ok_i` with count>0, pop the head. If head.kill=0, load the output register with the head metadata and `inst_rdata_i`. If head.kill=1, drop the return silently.
- **Simultaneous push and pop.** The count is unchanged; both pointers advance.
- **Redirect.** Set kill=1 on every valid entry. This includes a request accepted in the same cycle, since it still carries the pre-redirect PC. A return in the same cycle as a redirect is dropped.
- **Output suppression.** `FRT_valid_o = valid_q & ~redirect`. A group registered before a redirect is never presented during the redirect cycle.
- **Throttle.** `FRT_stopFetch_o = (count == DEPTH) | (live >= IQ_freeGroups_i)`, where live = count of entries with kill=0 plus valid_q.
- **Protocol error.** `inst_data_ok_i` with count==0 is ignored and sets `FRT_protoErr_o`, which clears only on reset.
- **Full FIFO.** An accept while count==DEPTH is a protocol error. No push occurs and `FRT_protoErr_o` is set.

## Timing
- **Reset (rst=0 at a posedge).** Pointers=0, count=0, all kill bits=0, valid_q=0, output data regs=0, `FRT_protoErr_o`=0.
- **Outputs during reset.** `FRT_stopFetch_o` reads 0, since live=0 and IQ_freeGroups_i is assumed >0 after reset. `FRT_outstanding_o`=0.
- **Latency.** `FRT_valid_o` rises exactly 1 cycle after the `inst_data_ok_i` edge and stays high for 1 cycle.
- **Pointer wrap.** Pointers wrap modulo DEPTH.
- **Count width.** The count is $clog2(DEPTH+1) bits, so DEPTH itself is representable.
- **`FRT_stopFetch_o` timing.** Combinational from registered state and `IQ_freeGroups_i`. It takes effect on PCRegister's `inst_req` in the same cycle.
- **Data-return ordering.** The I-Cache never asserts `inst_data_ok_i` in the same cycle as the accept of the request it answers.
- **Reset mid-operation.** All outstanding requests are discarded. Later returns with count==0 set `FRT_protoErr_o`, so the cache must be reset together with this block.

## Structure
- **Shared constants.** `SINGLE_WORD`, `EXCCODE`, `INST_NUM`, `ZEROWORD`, `FALSE` and the new `FRT_DEPTH` belong in MyDefines.v.
- **Sub-module `frt_meta_fifo`.** A parameterised DEPTH-entry register FIFO holding the metadata and kill bits.
  - Ports: push, pop, kill_all, head, count.
  - It exposes the kill-bit vector so `live` can be computed.
- **Top level.** Holds the output register, throttle logic and error flag.

## Test plan
- **Basic in-order return.** Accept VAddr 0xBFC00000, enable 4'b1111; data_ok 2 cycles later with rdata 0x…0123 → 1 cycle later `FRT_valid_o`=1, VAddr 0xBFC00000, inst 0x…0123; outstanding goes 1→0.
- **Fill to depth.** 4 back-to-back accepts with IQ_freeGroups=7 → `FRT_stopFetch_o`=1 once count=4. The next data_ok drops it to 0. Outputs appear in order 0x0, 0x10, 0x20, 0x30.
- **Redirect kills in-flight requests.** 3 outstanding, `SBA_flush_w_i` pulse in the same cycle as a 4th accept → the next 4 data_ok pulses produce no `FRT_valid_o`. The count drains 4→0.
- **Redirect during output.** A redirect in the cycle valid_q=1 → `FRT_valid_o`=0 that cycle.
- **Credit throttle.** IQ_freeGroups=1, one outstanding → stopFetch=1. IQ_freeGroups=2 → stopFetch=0.
- **Exception request and protocol error.** Accept with hasException=1, ExcCode ADEL → output inst=0, hasException=1, ExcCode ADEL. A data_ok with empty queue → `FRT_protoErr_o`=1 and stays set until rst=0.
